if_fetch_queue: RTL and testbench
=================================

// Module: if_fetch_queue
// PURPOSE
//  Instruction-fetch stage directly downstream of the program counter.
//  - Drives instruction memory with the PC address and tags each returned word with its PC.
//  - Buffers fetched words in a small FIFO that feeds decode over a valid/ready handshake.
//  - The PC advances every cycle and cannot stall. On overflow this block drops the word
//    and re-steers the PC through its Jump/JumpTo path (replay).
//  - An execute-stage redirect flushes all wrong-path state.
// PARAMETERS
//  ADDR_W  10  PC / instruction address width
//  DATA_W  32  instruction word width
//  DEPTH   4   FIFO entries; power of two, >=2
// PORTS
//  clk              in   1       clock; all state updates on posedge
//  Reset            in   1       synchronous, active-high reset
//  pc_addr          in   ADDR_W  current PC (Address output of the PC)
//  imem_addr        out  ADDR_W  instruction memory read address
//  imem_rdata       in   DATA_W  instruction memory data, synchronous read, 1-cycle latency
//  redirect_in      in   1       execute-stage taken branch/jump this cycle
//  replay_jump      out  1       request PC reload (ORed into PC Jump externally)
//  replay_target    out  ADDR_W  reload address (muxed into PC JumpTo; redirect has priority)
//  dec_valid        out  1       FIFO head valid
//  dec_ready        in   1       decode accepts head this cycle
//  dec_instr        out  DATA_W  head instruction word
//  dec_pc           out  ADDR_W  head instruction PC
// BEHAVIOUR
//  Reset and outputs
//  - Reset (sync, active-high): FIFO empty (count=0, pointers=0), valid_q=0, pc_q=0.
//  - Outputs during and after reset: dec_valid=0, replay_jump=0, replay_target=0, dec_pc=0, dec_instr=0.
//  Fetch and tagging
//  - imem_addr = pc_addr, combinational.
//  - Every posedge: pc_q <= pc_addr.
//  - valid_q <= !(Reset | redirect_in | replay_jump). This squashes the address presented in
//    a redirect/replay cycle, because the PC is reloaded at the same edge.
//  Handshake
//  - pop  = dec_valid & dec_ready.
//  - push = valid_q & (!full | pop). Entry pushed is {pc_q, imem_rdata}.
//  - Simultaneous push and pop while full is legal; count is unchanged.
//  - dec_valid = (count != 0). dec_instr/dec_pc show the head combinationally from the registered FIFO.
//  - Head is stable while dec_valid & !dec_ready.
//  Replay (overflow)
//  - replay_jump = valid_q & full & !pop & !redirect_in (combinational).
//  - replay_target = pc_q when replay_jump=1, else 0.
//  - On replay the word is dropped; the PC reloads pc_q at the same edge.
//  - Next cycle valid_q=0 (in-flight pc_q+1 squashed), so no gap and no duplicate.
//  - Replay repeats every second cycle while the FIFO remains full.
//  Redirect (flush)
//  - redirect_in=1: at that edge count<=0, pointers<=0, valid_q<=0.
//  - No push in that cycle; any pop that cycle is still treated as consumed by decode.
//  - redirect_in overrides replay_jump in the same cycle.
//  Latency
//  - First dec_valid is 2 cycles after the last edge with Reset=1 (dec_pc=0).
//  - Same 2-cycle latency after a redirect or a replay edge.
//  - Throughput: 1 instruction/cycle when dec_ready=1.
//  Width and priority
//  - FIFO pointers wrap modulo DEPTH; count spans 0..DEPTH (clog2(DEPTH)+1 bits).
//  - PC wrap 0x3FF->0x000 is passed through unmodified in the tags.
//  - Reset overrides redirect_in, which overrides replay and push/pop.
// TESTING
//  1. Reset 3 cycles, dec_ready=1, PC free-running
//     -> dec_valid=0 during reset; first dec_valid exactly 2 cycles after;
//        dec_pc=0,1,2,3... with imem word = f(pc).
//  2. dec_ready=0 from start
//     -> FIFO holds pc 0..3; replay_jump=1 with replay_target=4.
//     Then release dec_ready -> dec_pc sequence 0,1,2,3,4,5: no gap, no duplicate.
//  3. Streaming at pc=0x010, redirect_in=1 with PC jump to 0x100
//     -> dec_valid=0 next cycle; next accepted dec_pc=0x100 after 2 cycles;
//        no 0x011/0x012 delivered.
//  4. FIFO full with redirect_in=1 in the same cycle a replay would fire
//     -> replay_jump=0, FIFO empty, next dec_pc = redirect target.
//  5. Full FIFO with dec_ready=1 every cycle
//     -> simultaneous push/pop, count stays 4, replay_jump never asserts.
//  6. Reset asserted mid-stream with FIFO at count=3
//     -> next cycle dec_valid=0 and replay_jump=0; restart from dec_pc=0.
//  Also covered: PC wrap 0x3FE,0x3FF,0x000 -> tags delivered in that order.

Source files
------------

// File: rtl/if_fetch_queue.sv
// Instruction fetch stage: tags synchronous imem words with their PC and buffers them for decode.
// Overflow drops the word and replays the PC; an execute redirect flushes all wrong-path state.
module if_fetch_queue #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect_in,
    output logic              replay_jump,
    output logic [ADDR_W-1:0] replay_target,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [DATA_W-1:0] dec_instr,
    output logic [ADDR_W-1:0] dec_pc
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] instr_mem_q [DEPTH];
    logic [ADDR_W-1:0] pc_mem_q    [DEPTH];

    logic full, push, pop;

    assign imem_addr = pc_addr;
    assign full      = (count_q == CNT_W'(DEPTH));
    assign dec_valid = (count_q != '0);
    assign pop       = dec_valid & dec_ready;
    assign push      = valid_q & (!full | pop) & !redirect_in;

    // The PC cannot stall, so a word with nowhere to go is dropped and re-fetched.
    assign replay_jump   = valid_q & full & !pop & !redirect_in & !Reset;
    assign replay_target = replay_jump ? pc_q : '0;

    // Head is masked when empty so stale entries never leak out after reset or flush.
    assign dec_instr = dec_valid ? instr_mem_q[rd_ptr_q] : '0;
    assign dec_pc    = dec_valid ? pc_mem_q[rd_ptr_q]    : '0;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pc_d     = pc_addr;
        // The address presented in a redirect/replay cycle is overwritten by the PC reload.
        valid_d  = !(redirect_in | replay_jump);
        if (redirect_in) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            pc_q     <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            pc_q     <= pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!Reset && push) begin
            instr_mem_q[wr_ptr_q] <= imem_rdata;
            pc_mem_q[wr_ptr_q]    <= pc_q;
        end
    end
endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: a PC/imem model drives the DUT, a scoreboard
// queue holds the expected delivery order and a negedge monitor checks each handshake.
module tb_if_fetch_queue;
    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          Reset = 1'b1;
    logic [AW-1:0] pc_addr;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_rdata;
    logic          redirect_in = 1'b0;
    logic [AW-1:0] redir_tgt = '0;
    logic          replay_jump;
    logic [AW-1:0] replay_target;
    logic          dec_valid;
    logic          dec_ready = 1'b1;
    logic [DW-1:0] dec_instr;
    logic [AW-1:0] dec_pc;

    int checks = 0;
    int errors = 0;
    logic [AW-1:0] exp_q[$];

    if_fetch_queue #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(4)) dut (
        .clk(clk), .Reset(Reset), .pc_addr(pc_addr), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redirect_in(redirect_in), .replay_jump(replay_jump),
        .replay_target(replay_target), .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_instr(dec_instr), .dec_pc(dec_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] f(logic [AW-1:0] a);
        return {6'h2A, a, 6'h15, ~a};
    endfunction

    // Program counter with redirect priority over replay, plus 1-cycle imem.
    always @(posedge clk) begin
        if (Reset)            pc_addr <= '0;
        else if (redirect_in) pc_addr <= redir_tgt;
        else if (replay_jump) pc_addr <= replay_target;
        else                  pc_addr <= pc_addr + AW'(1);
        imem_rdata <= f(imem_addr);
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (dec_valid === 1'b1 && dec_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_delivery: got pc %h expected none at %0t", dec_pc, $time);
            end else begin
                logic [AW-1:0] e;
                e = exp_q.pop_front();
                chk("dec_pc", 32'(dec_pc), 32'(e));
                chk("dec_instr", dec_instr, f(e));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        Reset = 1'b1;
        dec_ready = 1'b0;
        redirect_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        Reset = 1'b0;
    endtask

    task automatic push_exp(int lo, int n);
        for (int i = 0; i < n; i++) exp_q.push_back(AW'(lo + i));
    endtask

    task automatic drain();
        for (int i = 0; i < 64; i++) begin
            @(posedge clk);
            if (exp_q.size() == 0) break;
        end
        #1;
        dec_ready = 1'b0;
        chk("drain_remaining", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // Stream from reset, redirect once pc_addr reaches stop_pc.
    task automatic redirect_test(int stop_pc, logic [AW-1:0] tgt);
        bit hit = 1'b0;
        do_reset();
        dec_ready = 1'b1;
        push_exp(0, stop_pc - 1);
        push_exp(int'(tgt), 4);
        for (int i = 0; i < 64; i++) begin
            step();
            if (pc_addr == AW'(stop_pc)) begin hit = 1'b1; break; end
        end
        chk("redir_reach_pc", 32'(hit), 32'd1);
        redirect_in = 1'b1;
        redir_tgt = tgt;
        step();
        redirect_in = 1'b0;
        @(negedge clk); chk("redir_flush_valid", 32'(dec_valid), 32'd0);
        step();
        @(negedge clk); chk("redir_lat1_valid", 32'(dec_valid), 32'd0);
        step();
        @(negedge clk); chk("redir_lat2_valid", 32'(dec_valid), 32'd1);
        chk("redir_first_pc", 32'(dec_pc), 32'(tgt));
        drain();
    endtask

    initial begin
        // 1: reset outputs, 2-cycle latency, free-running stream
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_dec_valid", 32'(dec_valid), 32'd0);
            chk("rst_replay_jump", 32'(replay_jump), 32'd0);
            chk("rst_replay_target", 32'(replay_target), 32'd0);
            chk("rst_dec_pc", 32'(dec_pc), 32'd0);
            chk("rst_dec_instr", dec_instr, 32'd0);
        end
        Reset = 1'b0;
        push_exp(0, 8);
        @(negedge clk); chk("lat1_valid", 32'(dec_valid), 32'd0);
        @(negedge clk); chk("lat2_valid", 32'(dec_valid), 32'd1);
        chk("lat2_pc", 32'(dec_pc), 32'd0);
        drain();

        // 2: overflow replay with decode stalled, then release
        do_reset();
        repeat (5) step();
        @(negedge clk);
        chk("ovf_replay", 32'(replay_jump), 32'd1);
        chk("ovf_target", 32'(replay_target), 32'd4);
        chk("ovf_head", 32'(dec_pc), 32'd0);
        step();
        @(negedge clk); chk("ovf_squash", 32'(replay_jump), 32'd0);
        step();
        @(negedge clk);
        chk("ovf_replay2", 32'(replay_jump), 32'd1);
        chk("ovf_target2", 32'(replay_target), 32'd4);
        step();
        push_exp(0, 8);
        dec_ready = 1'b1;
        drain();

        // 3: redirect while streaming; wrap: redirect to 0x3FE
        redirect_test(16, 10'h100);
        redirect_test(3, 10'h3FE);

        // 4: redirect in the cycle a replay would fire
        do_reset();
        repeat (5) step();
        redirect_in = 1'b1;
        redir_tgt = 10'h200;
        @(negedge clk); chk("redir_over_replay", 32'(replay_jump), 32'd0);
        step();
        redirect_in = 1'b0;
        dec_ready = 1'b1;
        @(negedge clk); chk("redir_full_flush", 32'(dec_valid), 32'd0);
        push_exp(10'h200, 4);
        drain();

        // 5: full FIFO streaming, occupancy stays at 4
        do_reset();
        repeat (5) step();
        dec_ready = 1'b1;
        push_exp(0, 16);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("full_stream_replay", 32'(replay_jump), 32'd0);
            chk("full_stream_depth", 32'(dec_pc), 32'(pc_addr - AW'(5)));
            step();
        end
        drain();

        // 6: reset mid-stream with 3 entries held
        do_reset();
        repeat (4) step();
        Reset = 1'b1;
        @(negedge clk); chk("mid_pre_valid", 32'(dec_valid), 32'd1);
        step();
        Reset = 1'b0;
        dec_ready = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", 32'(dec_valid), 32'd0);
        chk("mid_rst_replay", 32'(replay_jump), 32'd0);
        push_exp(0, 4);
        step();
        @(negedge clk); chk("mid_lat1_valid", 32'(dec_valid), 32'd0);
        step();
        @(negedge clk); chk("mid_lat2_valid", 32'(dec_valid), 32'd1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end
endmodule
